// File: rtl/pipeline_pkg.sv
// Shared fetch/decode pipeline types and constants.
package pipeline_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HAVE = 2'd3
  } fetch_state_t;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, keeps one imem request in flight, and feeds the
// FD register with an instruction, PC+4 and a bubble strobe.
module fetch_unit
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        haz_enable,
  input  logic        pc_src_d,
  input  logic [31:0] pc_target_d,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_f,
  output logic [31:0] pc_plus_4_f,
  output logic        sig_clr_fd
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  ibuf;
  logic         drop;
  logic         redirect;

  // A decode redirect only counts when the FD register is actually capturing.
  assign redirect = haz_enable & pc_src_d;

  // Request/response outputs come straight from registered state.
  assign imem_req    = (state == REQ);
  assign imem_addr   = pc;
  assign instr_f     = (state == HAVE) ? ibuf : INSTR_NOP;
  assign pc_plus_4_f = pc + PC_STEP;

  // Bubble whenever FD captures without a valid fetched instruction, or the
  // buffered one is being squashed. Never while stalled, so a held decode
  // instruction survives; forced low while reset is asserted.
  assign sig_clr_fd  = rst_n & haz_enable & ((state != HAVE) | pc_src_d);

  // Fetch FSM with inline PC register, drop flag and one-entry buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc    <= RESET_PC;
      ibuf  <= INSTR_NOP;
      drop  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (redirect) pc <= pc_target_d;
          state <= REQ;
        end
        REQ: begin
          // Address may only move while the request is still unaccepted.
          if (redirect) pc <= pc_target_d;
          if (imem_ready) begin
            state <= WAIT;
            // Accepted with the old address but redirected: squash the reply.
            drop  <= redirect;
          end
        end
        WAIT: begin
          if (redirect) pc <= pc_target_d;
          if (imem_rvalid) begin
            if (drop | redirect) begin
              drop  <= 1'b0;
              state <= REQ;
            end else begin
              ibuf  <= imem_rdata;
              state <= HAVE;
            end
          end else if (redirect) begin
            drop <= 1'b1;
          end
        end
        HAVE: begin
          if (redirect) begin
            pc    <= pc_target_d;
            state <= REQ;
          end else if (haz_enable) begin
            pc    <= pc + PC_STEP;
            state <= REQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; memory responses are driven by hand.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        haz_enable;
  logic        pc_src_d;
  logic [31:0] pc_target_d;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr_f;
  logic [31:0] pc_plus_4_f;
  logic        sig_clr_fd;

  int checks;
  int failures;

  fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .haz_enable  (haz_enable),
    .pc_src_d    (pc_src_d),
    .pc_target_d (pc_target_d),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_f     (instr_f),
    .pc_plus_4_f (pc_plus_4_f),
    .sig_clr_fd  (sig_clr_fd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; haz_enable = 1'b1; pc_src_d = 1'b0; pc_target_d = 32'h0;
    imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    tick(); tick();
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", imem_req); end
    checks++; if (imem_addr !== 32'h100) begin failures++; $display("FAIL rst_addr got=%h exp=00000100", imem_addr); end
    checks++; if (instr_f !== 32'h0) begin failures++; $display("FAIL rst_instr got=%h exp=00000000", instr_f); end
    checks++; if (pc_plus_4_f !== 32'h104) begin failures++; $display("FAIL rst_pc4 got=%h exp=00000104", pc_plus_4_f); end
    checks++; if (sig_clr_fd !== 1'b0) begin failures++; $display("FAIL rst_clr got=%b exp=0", sig_clr_fd); end
    rst_n = 1'b1;
    // First edge after release: IDLE -> REQ.
    tick();
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL first_req got=%b exp=1", imem_req); end
    checks++; if (imem_addr !== 32'h100) begin failures++; $display("FAIL first_addr got=%h exp=00000100", imem_addr); end
  endtask

  task automatic test_first_fetch();
    tick(); // accepted -> WAIT
    imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111;
    #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL ff_wait_req got=%b exp=0", imem_req); end
    checks++; if (sig_clr_fd !== 1'b1) begin failures++; $display("FAIL ff_wait_clr got=%b exp=1", sig_clr_fd); end
    tick(); // -> HAVE
    imem_rvalid = 1'b0;
    #1;
    checks++; if (instr_f !== 32'h1111_1111) begin failures++; $display("FAIL ff_instr got=%h exp=11111111", instr_f); end
    checks++; if (pc_plus_4_f !== 32'h104) begin failures++; $display("FAIL ff_pc4 got=%h exp=00000104", pc_plus_4_f); end
    checks++; if (sig_clr_fd !== 1'b0) begin failures++; $display("FAIL ff_have_clr got=%b exp=0", sig_clr_fd); end
    haz_enable = 1'b0; // stall before the next edge
  endtask

  task automatic test_stall_have();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (instr_f !== 32'h1111_1111) begin failures++; $display("FAIL stall_instr[%0d] got=%h exp=11111111", i, instr_f); end
      checks++; if (pc_plus_4_f !== 32'h104) begin failures++; $display("FAIL stall_pc4[%0d] got=%h exp=00000104", i, pc_plus_4_f); end
      checks++; if (sig_clr_fd !== 1'b0) begin failures++; $display("FAIL stall_clr[%0d] got=%b exp=0", i, sig_clr_fd); end
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL stall_req[%0d] got=%b exp=0", i, imem_req); end
    end
    haz_enable = 1'b1;
    tick(); // HAVE -> REQ, pc = 0x104
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL resume_req got=%b exp=1", imem_req); end
    checks++; if (imem_addr !== 32'h104) begin failures++; $display("FAIL resume_addr got=%h exp=00000104", imem_addr); end
  endtask

  task automatic test_redirect_wait();
    tick(); // request for 0x104 accepted -> WAIT
    pc_src_d = 1'b1; pc_target_d = 32'h200;
    #1;
    checks++; if (sig_clr_fd !== 1'b1) begin failures++; $display("FAIL rw_clr0 got=%b exp=1", sig_clr_fd); end
    tick(); // still WAIT, pc = 0x200, drop set
    pc_src_d = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    #1;
    checks++; if (imem_addr !== 32'h200) begin failures++; $display("FAIL rw_addr_next got=%h exp=00000200", imem_addr); end
    checks++; if (sig_clr_fd !== 1'b1) begin failures++; $display("FAIL rw_clr1 got=%b exp=1", sig_clr_fd); end
    tick(); // stale reply dropped -> REQ
    imem_rvalid = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL rw_req got=%b exp=1", imem_req); end
    checks++; if (imem_addr !== 32'h200) begin failures++; $display("FAIL rw_addr got=%h exp=00000200", imem_addr); end
    checks++; if (instr_f !== 32'h0) begin failures++; $display("FAIL rw_no_have got=%h exp=00000000", instr_f); end
    checks++; if (sig_clr_fd !== 1'b1) begin failures++; $display("FAIL rw_clr2 got=%b exp=1", sig_clr_fd); end
    tick(); // accepted -> WAIT
    imem_rvalid = 1'b1; imem_rdata = 32'h2222_2222;
    tick(); // -> HAVE
    imem_rvalid = 1'b0;
    #1;
    checks++; if (instr_f !== 32'h2222_2222) begin failures++; $display("FAIL rw_instr got=%h exp=22222222", instr_f); end
    checks++; if (pc_plus_4_f !== 32'h204) begin failures++; $display("FAIL rw_pc4 got=%h exp=00000204", pc_plus_4_f); end
  endtask

  task automatic test_redirect_have();
    // Still in HAVE from the previous task, before its advancing edge.
    imem_ready = 1'b0; pc_src_d = 1'b1; pc_target_d = 32'h300;
    #1;
    checks++; if (sig_clr_fd !== 1'b1) begin failures++; $display("FAIL rh_clr got=%b exp=1", sig_clr_fd); end
    tick(); // -> REQ at 0x300
    pc_src_d = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL rh_req[%0d] got=%b exp=1", i, imem_req); end
      checks++; if (imem_addr !== 32'h300) begin failures++; $display("FAIL rh_addr[%0d] got=%h exp=00000300", i, imem_addr); end
      if (i == 0) tick();
    end
    imem_ready = 1'b1;
    tick(); // accepted -> WAIT
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rh_accept got=%b exp=0", imem_req); end
    imem_rvalid = 1'b1; imem_rdata = 32'h3333_3333;
    tick(); // -> HAVE
    imem_rvalid = 1'b0;
    #1;
    checks++; if (instr_f !== 32'h3333_3333) begin failures++; $display("FAIL rh_instr got=%h exp=33333333", instr_f); end
  endtask

  task automatic test_wrap();
    pc_src_d = 1'b1; pc_target_d = 32'hFFFF_FFFC;
    tick(); // HAVE -> REQ at 0xFFFFFFFC
    pc_src_d = 1'b0;
    #1;
    checks++; if (imem_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_addr got=%h exp=fffffffc", imem_addr); end
    checks++; if (pc_plus_4_f !== 32'h0) begin failures++; $display("FAIL wrap_pc4 got=%h exp=00000000", pc_plus_4_f); end
    tick(); // -> WAIT
    imem_rvalid = 1'b1; imem_rdata = 32'h4444_4444;
    tick(); // -> HAVE
    imem_rvalid = 1'b0;
    #1;
    checks++; if (instr_f !== 32'h4444_4444) begin failures++; $display("FAIL wrap_instr got=%h exp=44444444", instr_f); end
    checks++; if (pc_plus_4_f !== 32'h0) begin failures++; $display("FAIL wrap_have_pc4 got=%h exp=00000000", pc_plus_4_f); end
    tick(); // advance -> REQ at 0x0
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL wrap_next got=%h exp=00000000", imem_addr); end
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL wrap_req got=%b exp=1", imem_req); end
  endtask

  task automatic test_reset_mid_wait();
    tick(); // request at 0x0 accepted -> WAIT
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rmw_wait got=%b exp=0", imem_req); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rmw_req got=%b exp=0", imem_req); end
    checks++; if (imem_addr !== 32'h100) begin failures++; $display("FAIL rmw_addr got=%h exp=00000100", imem_addr); end
    checks++; if (instr_f !== 32'h0) begin failures++; $display("FAIL rmw_instr got=%h exp=00000000", instr_f); end
    checks++; if (pc_plus_4_f !== 32'h104) begin failures++; $display("FAIL rmw_pc4 got=%h exp=00000104", pc_plus_4_f); end
    checks++; if (sig_clr_fd !== 1'b0) begin failures++; $display("FAIL rmw_clr got=%b exp=0", sig_clr_fd); end
    tick();
    rst_n = 1'b1;
    tick(); // IDLE -> REQ
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL rmw_restart_req got=%b exp=1", imem_req); end
    checks++; if (imem_addr !== 32'h100) begin failures++; $display("FAIL rmw_restart_addr got=%h exp=00000100", imem_addr); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_first_fetch();
    test_stall_have();
    test_redirect_wait();
    test_redirect_have();
    test_wrap();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
